mul_arbiter: RTL
================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter W, default 32: operand width; result width is 2*W.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operand pair.
REQ-005 req0_ready / req1_ready  output  1  operand pair of requester n accepted this cycle.
REQ-006 req0_src1, req0_src2, req1_src1, req1_src2  input  W  operands; src1 is the multiplier, src2 the sign-extended multiplicand.
REQ-007 rsp0_valid / rsp1_valid  output  1  result for requester n is held.
REQ-008 rsp0_ready / rsp1_ready  input  1  requester n consumes the result.
REQ-009 rsp_result  output  2W  buffered product, shared by both response ports.
REQ-010 mul_in_valid  output  1  issue request to the shared multiplier.
REQ-011 mul_in_ready  input  1  multiplier is idle and can accept an issue.
REQ-012 mul_src1, mul_src2  output  W  operands to the multiplier.
REQ-013 mul_out_valid  input  1  one-cycle completion pulse from the multiplier; it has no backpressure.
REQ-014 mul_result  input  2W  multiplier product, sampled only on mul_out_valid.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; only one operation is in flight at a time.
REQ-016 IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready combinationally for that cycle, latch its src1/src2 and owner id, then go to ISSUE.
REQ-017 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; the last-grant pointer updates only on a grant.
REQ-018 Only the granted requester's ready SHALL be high, and only in IDLE; at most one reqN_ready is high per cycle.
REQ-019 ISSUE: assert mul_in_valid with the latched operands; on mul_in_valid && mul_in_ready go to WAIT; hold otherwise.
REQ-020 WAIT: on mul_out_valid latch mul_result into the result buffer and go to RESP.
REQ-021 A mul_out_valid pulse in IDLE, ISSUE or RESP SHALL be ignored.
REQ-022 RESP: assert rsp<owner>_valid and drive rsp_result from the buffer, stable until rsp<owner>_ready; on handshake go to IDLE.
REQ-023 The non-owner's rspN_valid SHALL stay low, and rspN_ready is ignored when rspN_valid is low.
REQ-024 Latency SHALL be fixed overhead plus multiplier time:
- grant cycle (IDLE) -> ISSUE at +1;
- result visible on rsp the cycle after mul_out_valid.
REQ-025 Operands SHALL pass unmodified, and the product SHALL pass bit-exact; the block performs no arithmetic.
REQ-026 A requester whose valid drops before grant SHALL simply not be granted; no request state is retained for it.

Reset
REQ-027 With resetn low at a clk edge:
- state goes to IDLE;
- last-grant pointer set to requester 1, so requester 0 wins the first tie;
- all valid/ready outputs go to 0.
REQ-028 Reset mid-operation (ISSUE, WAIT or RESP) SHALL abandon the operation without emitting a response; the multiplier is reset on the same resetn.
REQ-029 Operand and result buffers need no reset; mul_src1/mul_src2/rsp_result are don't-care while their valids are low.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef/encodings and the default W.
REQ-031 One sub-module, rr_arb2, SHALL implement the 2-way round-robin grant: inputs req[1:0], last pointer, enable; output one-hot grant.
REQ-032 Target size: 120–250 lines of RTL.

Verification
REQ-033 req0 only, src1=3, src2=5, rsp0_ready=1 -> rsp0_valid with rsp_result=64'd15, rsp1_valid never high.
REQ-034 Both valid from reset, four ops each -> grants alternate 0,1,0,1…, each rsp on the matching port.
REQ-035 req1 src1=3, src2=32'hFFFFFFF9 (-7) -> rsp_result=64'hFFFFFFFFFFFFFFEB (-21).
REQ-036 rsp0_ready held low 10 cycles after result -> rsp0_valid and rsp_result stable, no new req_ready, completes when ready rises.
REQ-037 resetn low during WAIT -> next cycle IDLE, no rsp pulse, next operation (src1=0, src2=9) returns 0 correctly.
REQ-038 mul_in_ready low for 5 cycles in ISSUE -> mul_in_valid and operands held stable throughout.

Source files
------------

// File: rtl/mul_arbiter_pkg.sv
// rtl/mul_arbiter_pkg.sv - shared FSM encoding and default operand width for the multiply arbiter
package mul_arbiter_pkg;

  localparam int MUL_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; a tie goes to the requester not granted last
module rr_arb2 (
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - shares one multiplier between two requesters, one operation in flight
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int W = MUL_W_DEFAULT
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [W-1:0]   req0_src1,
  input  logic [W-1:0]   req0_src2,
  input  logic [W-1:0]   req1_src1,
  input  logic [W-1:0]   req1_src2,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  input  logic           rsp0_ready,
  input  logic           rsp1_ready,
  output logic [2*W-1:0] rsp_result,
  output logic           mul_in_valid,
  input  logic           mul_in_ready,
  output logic [W-1:0]   mul_src1,
  output logic [W-1:0]   mul_src2,
  input  logic           mul_out_valid,
  input  logic [2*W-1:0] mul_result
);

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic           owner_q, owner_d;
  logic [W-1:0]   src1_q, src2_q;
  logic [2*W-1:0] result_q;
  logic [1:0]     gnt;
  logic           grant_any;
  logic           issue_fire;
  logic           rsp_fire;

  rr_arb2 u_arb (
    .en_i   (state_q == ST_IDLE),
    .req_i  ({req1_valid, req0_valid}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign grant_any  = |gnt;
  assign issue_fire = (state_q == ST_ISSUE) && mul_in_ready;
  assign rsp_fire   = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  // Data buffers carry no reset: they are only observed while a valid qualifies them.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      src1_q <= gnt[1] ? req1_src1 : req0_src1;
      src2_q <= gnt[1] ? req1_src2 : req0_src2;
    end
    if ((state_q == ST_WAIT) && mul_out_valid) begin
      result_q <= mul_result;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          state_d = ST_ISSUE;
          owner_d = gnt[1];
          last_d  = gnt[1];
        end
      end
      ST_ISSUE: if (issue_fire) state_d = ST_WAIT;
      ST_WAIT:  if (mul_out_valid) state_d = ST_RESP;
      ST_RESP:  if (rsp_fire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = gnt[0];
    req1_ready   = gnt[1];
    mul_in_valid = (state_q == ST_ISSUE);
    rsp0_valid   = (state_q == ST_RESP) && !owner_q;
    rsp1_valid   = (state_q == ST_RESP) && owner_q;
  end

  assign mul_src1   = src1_q;
  assign mul_src2   = src2_q;
  assign rsp_result = result_q;

endmodule
